// File: rtl/sysid_access_arbiter.sv
// rtl/sysid_access_arbiter.sv - round-robin access arbiter for the system-ID slave with boot-time ID self-check
module sysid_access_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] EXPECTED_ID = 32'd1379086204
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [31:0]        rsp_data,
  output logic               sys_address,
  input  logic [31:0]        sys_readdata,
  output logic               id_done,
  output logic               id_match,
  output logic               busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_READ,
    ST_RESP,
    ST_IDLE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          addr_q;
  logic [OW-1:0] owner_q;
  logic          internal_q;
  logic [3:0]    wait_cnt;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] rr_next;
  int            rr_int;

  logic          pick_found;
  logic [OW-1:0] pick_idx;
  logic          pick_addr;
  logic          owner_hit;

  assign rr_int  = int'(rr_ptr);
  assign rr_next = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Candidate k positions after rr_ptr; only indices below NUM_REQ can ever match.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_addr  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_found && req[j] &&
            ((j == rr_int + k) || (j == rr_int + k - NUM_REQ))) begin
          pick_found = 1'b1;
          pick_idx   = OW'(j);
          pick_addr  = req_addr[j];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b1;
    sys_address = 1'b0;
    gnt         = '0;
    rsp_valid   = '0;
    owner_hit   = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_READ;
      ST_READ: begin
        sys_address = addr_q;
        if (wait_cnt == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      ST_IDLE: begin
        busy = 1'b0;
        if (pick_found) begin
          state_next = ST_READ;
        end
      end
      default: state_next = ST_BOOT;
    endcase
    // The boot read has no requester, so it never raises gnt or rsp_valid.
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_hit    = !internal_q && (owner_q == OW'(i));
      gnt[i]       = owner_hit && ((state == ST_READ) || (state == ST_RESP));
      rsp_valid[i] = owner_hit && (state == ST_RESP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= 1'b0;
      owner_q    <= '0;
      internal_q <= 1'b1;
      wait_cnt   <= 4'd0;
      rsp_data   <= 32'd0;
      id_done    <= 1'b0;
      id_match   <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          addr_q     <= 1'b1;
          internal_q <= 1'b1;
          wait_cnt   <= 4'(WAIT_CYCLES);
        end
        ST_IDLE: begin
          if (pick_found) begin
            addr_q     <= pick_addr;
            owner_q    <= pick_idx;
            internal_q <= 1'b0;
            wait_cnt   <= 4'(WAIT_CYCLES);
          end
        end
        ST_READ: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rsp_data <= sys_readdata;
          end
        end
        ST_RESP: begin
          if (internal_q) begin
            id_done  <= 1'b1;
            id_match <= (rsp_data == EXPECTED_ID);
          end else begin
            rr_ptr <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// tb/tb_sysid_access_arbiter.sv - randomized scoreboard bench for sysid_access_arbiter
module tb_sysid_access_arbiter;

  localparam int          N      = 3;
  localparam int          W      = 2;
  localparam logic [31:0] EXP_ID = 32'h52332F7C;
  localparam int          HD     = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_addr = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;
  logic [31:0]   sys_readdata;
  logic          sys_address;
  logic          id_done;
  logic          id_match;
  logic          busy;

  logic [31:0]   mem0 = 32'd0;
  logic [31:0]   mem1 = EXP_ID;
  logic [31:0]   boot_id = EXP_ID;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  sysid_access_arbiter #(
    .NUM_REQ     (N),
    .WAIT_CYCLES (W),
    .EXPECTED_ID (EXP_ID)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .sys_address  (sys_address),
    .sys_readdata (sys_readdata),
    .id_done      (id_done),
    .id_match     (id_match),
    .busy         (busy)
  );

  // Combinational slave whose two words may change every cycle.
  assign sys_readdata = sys_address ? mem1 : mem0;

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int   rcyc;
    int   owner;
    logic addr;
  } exp_t;

  exp_t         sbq[$];
  logic [N-1:0] req_h [HD];
  logic [N-1:0] addr_h[HD];
  logic [31:0]  m0_h  [HD];
  logic [31:0]  m1_h  [HD];

  // Transaction-level reference: the server is free from free_at on; each grant occupies 3+W cycles.
  int           free_at = 3 + W;
  int           cur_g = 0;
  int           cur_owner = 0;
  int           rr = 0;
  int           t;
  int           ix;
  int           w;
  logic         cur_addr = 1'b0;
  logic         cur_valid = 1'b0;
  logic         found_w;
  logic [N-1:0] exp_gnt;
  logic         exp_sa;
  logic         exp_busy;
  logic         exp_done;
  logic         exp_match;

  always @(negedge clock) begin
    if (reset) begin
      sbq.delete();
      free_at   = 3 + W;
      cur_valid = 1'b0;
      rr        = 0;
      check("rst_gnt",       32'(gnt),         32'd0);
      check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
      check("rst_rsp_data",  rsp_data,         32'd0);
      check("rst_sys_addr",  32'(sys_address), 32'd0);
      check("rst_id_done",   32'(id_done),     32'd0);
      check("rst_id_match",  32'(id_match),    32'd0);
      check("rst_busy",      32'(busy),        32'd1);
    end else begin
      t  = cyc;
      ix = t % HD;
      req_h[ix]  = req;
      addr_h[ix] = req_addr;
      m0_h[ix]   = mem0;
      m1_h[ix]   = mem1;

      exp_busy = (t < free_at);
      exp_gnt  = '0;
      exp_sa   = 1'b0;
      if (t < 3 + W) begin
        exp_sa = (t >= 1) && (t <= 1 + W);
      end else if (cur_valid && (t > cur_g) && (t <= cur_g + 2 + W)) begin
        exp_gnt = N'(1) << cur_owner;
        exp_sa  = (t <= cur_g + 1 + W) ? cur_addr : 1'b0;
      end
      exp_done  = (t >= 3 + W);
      exp_match = exp_done && (m1_h[(1 + W) % HD] == EXP_ID);

      check("busy",     32'(busy),        32'(exp_busy));
      check("gnt",      32'(gnt),         32'(exp_gnt));
      check("sys_addr", 32'(sys_address), 32'(exp_sa));
      check("id_done",  32'(id_done),     32'(exp_done));
      check("id_match", 32'(id_match),    32'(exp_match));

      if ((t >= free_at) && (req_h[ix] != '0)) begin
        found_w = 1'b0;
        for (int k = 0; k < N; k++) begin
          w = (rr + k) % N;
          if (!found_w && req_h[ix][w]) begin
            found_w   = 1'b1;
            cur_owner = w;
          end
        end
        cur_addr  = addr_h[ix][cur_owner];
        cur_g     = t;
        cur_valid = 1'b1;
        free_at   = t + 3 + W;
        rr        = (cur_owner + 1) % N;
        sbq.push_back('{t + 2 + W, cur_owner, cur_addr});
      end
    end
  end

  exp_t e;

  always @(negedge clock) begin
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("rsp_cycle", cyc, e.rcyc);
          check("rsp_owner", 32'(rsp_valid), 32'(N'(1) << e.owner));
          check("rsp_data", rsp_data, e.addr ? m1_h[(cyc - 1) % HD] : m0_h[(cyc - 1) % HD]);
        end
      end else if ((sbq.size() != 0) && (sbq[0].rcyc <= cyc)) begin
        e = sbq.pop_front();
        check("rsp_missing", 32'(rsp_valid), 32'(N'(1) << e.owner));
      end
    end
  end

  // Requester state: 0 idle, 1 requesting, 2 abandoned after grant (awaiting the ignored response).
  int st[N];

  task automatic drive_cycle(input int load);
    logic [N-1:0] rv;
    logic [N-1:0] gv;
    @(negedge clock);
    rv = rsp_valid;
    gv = gnt;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rv[i]) begin
        if (st[i] == 1 && load > 0 && $urandom_range(0, 3) == 0) st[i] = 1;
        else st[i] = 0;
      end else if (st[i] == 1 && gv[i] && $urandom_range(0, 7) == 0) begin
        st[i] = 2;
      end else if (st[i] == 0 && load > 0 && $urandom_range(1, 100) <= 32'(load)) begin
        st[i] = 1;
      end
      req[i]      = (st[i] == 1);
      req_addr[i] = 1'($urandom_range(0, 1));
    end
    mem0 = $urandom;
    if (cyc <= 2 + W) mem1 = boot_id;
    else if ($urandom_range(0, 3) == 0) mem1 = EXP_ID;
    else mem1 = $urandom;
  endtask

  logic found_read;

  initial begin
    for (int i = 0; i < N; i++) st[i] = 0;
    st[0]    = 1;
    req      = N'(1);
    req_addr = N'(1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    repeat (300) drive_cycle(30);
    repeat (200) drive_cycle(100);

    boot_id    = 32'd0;
    found_read = 1'b0;
    for (int k = 0; k < 200 && !found_read; k++) begin
      drive_cycle(100);
      if (gnt != '0 && rsp_valid == '0) found_read = 1'b1;
    end
    check("find_read_phase", 32'(found_read), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) if (st[i] == 2) st[i] = 0;
    drive_cycle(0);
    reset = 1'b0;

    repeat (300) drive_cycle(50);
    repeat (200) drive_cycle(100);
    repeat (80) drive_cycle(0);

    check("drain_req",   32'(req),        32'd0);
    check("drain_queue", sbq.size(),      32'd0);
    check("drain_busy",  32'(busy),       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
